axioma_int_controller: RTL

Fixed-priority interrupt controller for the AxiomaCore-328 CPU. It latches interrupt requests from all peripherals: external INT0/INT1, USART, Timer0/1, SPI, TWI and ADC. It arbitrates them in ATmega328P vector order, where the lowest vector number wins, and runs a request/acknowledge/return handshake with the CPU core. It replaces the flat OR/priority mux at CPU-integration level and returns a one-cycle clear pulse to the serviced peripheral's flag.

---
 rtl/axioma_int_controller.sv | 131 +++++++++++++
 1 files changed

// File: rtl/axioma_int_controller.sv
// Fixed-priority interrupt controller for AxiomaCore-328: sticky pending capture,
// lowest-vector-wins arbitration and a req/ack/done handshake with the CPU core.

module axioma_int_pend_cell (
  input  logic clk,
  input  logic reset_n,
  input  logic src,
  input  logic clr,
  output logic pend
);
  // Clear wins over a same-cycle source: a re-assert on its own ack cycle is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pend <= 1'b0;
    else          pend <= clr ? 1'b0 : (pend | src);
  end
endmodule

module axioma_int_controller #(
  parameter int NUM_VEC = 26,
  parameter int VEC_W   = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_VEC-1:0] irq_src,
  input  logic [NUM_VEC-1:0] irq_mask,
  input  logic               global_ie,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic               irq_req,
  output logic [VEC_W-1:0]   irq_vector,
  output logic [NUM_VEC-1:0] irq_clear,
  output logic [NUM_VEC-1:0] debug_pending,
  output logic [1:0]         debug_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } state_t;

  state_t             state;
  logic [NUM_VEC-1:0] pending;
  logic [NUM_VEC-1:0] cand;
  logic [NUM_VEC-1:0] vec_onehot;
  logic [NUM_VEC-1:0] clr_vec;
  logic [VEC_W-1:0]   winner;
  logic               any_cand;
  logic               ack_fire;
  logic               mask_hit;
  logic               src0_unused;

  // Slot 0 is the reset vector and never requests.
  assign src0_unused = irq_src[0];
  assign pending[0]  = 1'b0;

  genvar g;
  generate
    for (g = 1; g < NUM_VEC; g++) begin : g_pend
      axioma_int_pend_cell u_pend (
        .clk     (clk),
        .reset_n (reset_n),
        .src     (irq_src[g]),
        .clr     (clr_vec[g]),
        .pend    (pending[g])
      );
    end
  endgenerate

  assign cand     = pending & irq_mask;
  assign any_cand = |cand;

  // Scan high to low so the lowest set index is the last write.
  always_comb begin
    winner = '0;
    for (int n = NUM_VEC - 1; n >= 1; n--) begin
      if (cand[n]) winner = VEC_W'(n);
    end
  end

  always_comb begin
    vec_onehot = '0;
    for (int n = 0; n < NUM_VEC; n++) begin
      vec_onehot[n] = (irq_vector == VEC_W'(n));
    end
  end

  assign ack_fire = (state == REQ) && irq_ack;
  assign clr_vec  = ack_fire ? vec_onehot : '0;
  assign mask_hit = |(vec_onehot & irq_mask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      irq_req    <= 1'b0;
      irq_vector <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (global_ie && any_cand) begin
            state      <= REQ;
            irq_vector <= winner;
            irq_req    <= 1'b1;
          end
        end
        REQ: begin
          // Vector stays frozen here; ack beats withdraw in the same cycle.
          if (irq_ack) begin
            state   <= SERVICE;
            irq_req <= 1'b0;
          end else if (!global_ie || !mask_hit) begin
            state   <= IDLE;
            irq_req <= 1'b0;
          end
        end
        SERVICE: begin
          if (irq_done) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

  assign irq_clear     = clr_vec;
  assign debug_pending = pending;
  assign debug_state   = state;

endmodule
